fp32_div_seq: RTL and testbench

- Sequential IEEE-754 single-precision divider. It is the inverse-direction companion of the floating-point multiplier datapath: it divides instead of multiplying.
- Mantissas are divided with a restoring shift/subtract loop, one quotient bit per clock, using one ripple subtractor.
- Operands and results are on a start/valid handshake, so a controller can issue a divide and collect the quotient.

---
 rtl/fp32_pkg.sv | 21 ++
 rtl/sub_25bits.sv | 39 +++
 rtl/fp32_div_seq.sv | 180 ++++++++++++++++++
 tb/tb_fp32_div_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 constants, field layout and divider FSM states.
package fp32_pkg;

  localparam int          EXP_BIAS     = 127;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [30:0] FP32_INF_MAG = 31'h7F800000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    ROUND,
    DONE
  } div_state_e;

endpackage

// File: rtl/sub_25bits.sv
// 25-bit ripple subtractor: a + ~b + 1 through a chain of full_adder cells.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module sub_25bits (
  input  logic [24:0] i_data_one,
  input  logic [24:0] i_data_two,
  output logic [24:0] o_data,
  output logic        o_borrow
);

  logic [25:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < 25; i++) begin : g_fa
    full_adder u_fa (
      .i_a    (i_data_one[i]),
      .i_b    (~i_data_two[i]),
      .i_cin  (carry[i]),
      .o_sum  (o_data[i]),
      .o_cout (carry[i+1])
    );
  end

  // A missing carry-out means the subtrahend was larger.
  assign o_borrow = ~carry[25];

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential fp32 divider: restoring mantissa division, one quotient bit per
// clock, round-to-nearest-even, denormals flushed to zero.
module fp32_div_seq
  import fp32_pkg::*;
#(
  parameter int Q_BITS = 26,
  parameter int CNT_W  = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_data_one,
  input  logic [31:0] i_data_two,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_div_zero,
  output logic        o_invalid
);

  div_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [24:0]        rem;
  logic [23:0]        mb;
  logic [Q_BITS-1:0]  q;
  logic signed [9:0]  exp_r;
  logic               sign_r;

  fp32_t              op_a, op_b;
  logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic               sign_in, is_special, spec_dz, spec_inv;
  logic [31:0]        spec_data;
  logic signed [9:0]  exp_in;

  logic [24:0]        diff;
  logic               borrow;

  logic [23:0]        mant, mant_fin;
  logic [24:0]        mant_inc;
  logic               guard, sticky, round_up;
  logic signed [9:0]  e_norm, e_fin;
  logic [31:0]        norm_data;

  assign op_a    = i_data_one;
  assign op_b    = i_data_two;
  assign sign_in = op_a.sign ^ op_b.sign;
  assign exp_in  = 10'({2'b00, op_a.exp}) - 10'({2'b00, op_b.exp}) + 10'(EXP_BIAS);

  // Operand classification; exponent 0 covers both zero and flushed denormals.
  always_comb begin
    a_zero = (op_a.exp == 8'h00);
    a_inf  = (op_a.exp == 8'hFF) && (op_a.frac == '0);
    a_nan  = (op_a.exp == 8'hFF) && (op_a.frac != '0);
    b_zero = (op_b.exp == 8'h00);
    b_inf  = (op_b.exp == 8'hFF) && (op_b.frac == '0);
    b_nan  = (op_b.exp == 8'hFF) && (op_b.frac != '0);

    is_special = 1'b1;
    spec_data  = '0;
    spec_dz    = 1'b0;
    spec_inv   = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_data = FP32_QNAN;
      spec_inv  = 1'b1;
    end else if (a_inf) begin
      spec_data = {sign_in, FP32_INF_MAG};
    end else if (b_inf) begin
      spec_data = {sign_in, 31'b0};
    end else if (b_zero) begin
      spec_data = {sign_in, FP32_INF_MAG};
      spec_dz   = 1'b1;
    end else if (a_zero) begin
      spec_data = {sign_in, 31'b0};
    end else begin
      is_special = 1'b0;
    end
  end

  sub_25bits u_sub (
    .i_data_one (rem),
    .i_data_two ({1'b0, mb}),
    .o_data     (diff),
    .o_borrow   (borrow)
  );

  always_comb begin
    if (q[25]) begin
      mant   = q[25:2];
      guard  = q[1];
      sticky = q[0] | (rem != '0);
      e_norm = exp_r;
    end else begin
      mant   = q[24:1];
      guard  = q[0];
      sticky = (rem != '0);
      e_norm = exp_r - 10'sd1;
    end

    round_up = guard & (sticky | mant[0]);
    mant_inc = {1'b0, mant} + 25'(round_up);
    if (mant_inc[24]) begin
      mant_fin = 24'h800000;
      e_fin    = e_norm + 10'sd1;
    end else begin
      mant_fin = mant_inc[23:0];
      e_fin    = e_norm;
    end

    if (e_fin >= 10'sd255) begin
      norm_data = {sign_r, FP32_INF_MAG};
    end else if (e_fin <= 10'sd0) begin
      norm_data = {sign_r, 31'b0};
    end else begin
      norm_data = {sign_r, e_fin[7:0], mant_fin[22:0]};
    end
  end

  // Control FSM; special operand pairs skip straight to DONE with the answer ready.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      mb         <= '0;
      q          <= '0;
      exp_r      <= '0;
      sign_r     <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_div_zero <= 1'b0;
      o_invalid  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            if (is_special) begin
              o_data     <= spec_data;
              o_div_zero <= spec_dz;
              o_invalid  <= spec_inv;
              o_valid    <= 1'b1;
              state      <= DONE;
            end else begin
              rem    <= {2'b01, op_a.frac};
              mb     <= {1'b1, op_b.frac};
              q      <= '0;
              cnt    <= '0;
              exp_r  <= exp_in;
              sign_r <= sign_in;
              state  <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          q   <= {q[Q_BITS-2:0], ~borrow};
          rem <= borrow ? (rem << 1) : (diff << 1);
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(Q_BITS - 1)) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          o_data     <= norm_data;
          o_div_zero <= 1'b0;
          o_invalid  <= 1'b0;
          o_valid    <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Scoreboard bench for fp32_div_seq: directed vectors push expectations, a
// negedge monitor pops and compares each o_valid result including its latency.
module tb_fp32_div_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [31:0] i_data_one;
  logic [31:0] i_data_two;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_busy;
  logic        o_div_zero;
  logic        o_invalid;

  typedef struct {
    logic [31:0] q;
    logic        dz;
    logic        inv;
    int          exp_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dz;
    logic        inv;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  fp32_div_seq dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_data_one (i_data_one),
    .i_data_two (i_data_two),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_div_zero (o_div_zero),
    .o_invalid  (o_invalid)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one start pulse; the expected cycle of o_valid is relative to the
  // acceptance edge, which is the posedge right after this negedge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] q, input logic dz, input logic inv,
                               input int lat, input bit push);
    exp_t e;
    @(negedge i_clk);
    i_data_one = a;
    i_data_two = b;
    i_start    = 1'b1;
    if (push) begin
      e.q       = q;
      e.dz      = dz;
      e.inv     = inv;
      e.exp_cyc = cyc + lat;
      sb.push_back(e);
    end
    @(negedge i_clk);
    i_start    = 1'b0;
    i_data_one = $urandom;
    i_data_two = $urandom;
  endtask

  task automatic waitIdle();
    int k = 0;
    while (o_busy && k < 40) begin
      @(negedge i_clk);
      k++;
    end
    if (o_busy) checkOutput("busy_timeout", 32'(o_busy), 32'd0);
  endtask

  always @(negedge i_clk) begin
    if (o_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", {o_div_zero, o_invalid, o_data[29:0]}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("data", o_data, e.q);
        checkOutput("div_zero", 32'(o_div_zero), 32'(e.dz));
        checkOutput("invalid", 32'(o_invalid), 32'(e.inv));
        checkOutput("latency", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  vec_t vecs[15] = '{
    '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28},
    '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 28},
    '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 28},
    '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1},
    '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 1},
    '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 1'b0, 1'b0, 28},
    '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 1'b0, 1'b0, 28},
    '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1},
    '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 1},
    '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 1},
    '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0, 1},
    '{32'hBF800000, 32'h7F800000, 32'h80000000, 1'b0, 1'b0, 1},
    '{32'hC0000000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, 1},
    '{32'h40000000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 28},
    '{32'h3FC00000, 32'h3FC00000, 32'h3F800000, 1'b0, 1'b0, 28}
  };

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_data_one = '0;
    i_data_two = '0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset_data", o_data, 32'h0);
    checkOutput("reset_ctrl", {28'h0, o_valid, o_busy, o_div_zero, o_invalid}, 32'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dz, vecs[i].inv, vecs[i].lat, 1'b1);
      waitIdle();
    end

    // Start pulse at T+5 with different operands must be ignored.
    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28, 1'b1);
    repeat (4) @(negedge i_clk);
    i_data_one = 32'h3F800000;
    i_data_two = 32'h00000000;
    i_start    = 1'b1;
    @(negedge i_clk);
    i_start    = 1'b0;
    waitIdle();
    repeat (5) @(negedge i_clk);

    // Reset asserted at T+10 aborts the divide without a result.
    applyStimulus(32'h40C00000, 32'h40000000, 32'h0, 1'b0, 1'b0, 28, 1'b0);
    repeat (9) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checkOutput("abort_data", o_data, 32'h0);
    checkOutput("abort_ctrl", {28'h0, o_valid, o_busy, o_div_zero, o_invalid}, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (30) @(negedge i_clk);
    checkOutput("abort_idle", 32'(o_busy), 32'd0);

    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28, 1'b1);
    waitIdle();
    repeat (3) @(negedge i_clk);

    checkOutput("pending_results", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
